gate_vector_checker: RTL and testbench
======================================

Name: gate_vector_checker

Overview:
- Synthesizable, self-checking stimulus/response engine. It is the DUT-facing counterpart of the team's gate testbenches.
- Holds a small truth-table memory of input and expected-output vectors. It drives each vector onto a combinational gate under test, waits a settle time, samples the gate output and compares it.
- Reports pass/fail count, first failing index and an overall verdict.
- Sits beside any gate (Not, And, Mux…) in on-board and FPGA bring-up builds.

Parameters:
- N_IN, 1: width of the DUT input vector.
- N_OUT, 1: width of the DUT output vector.
- N_VEC, 2: number of vector-table entries (≥1).
- SETTLE, 1: wait cycles between driving dut_in and sampling dut_out (≥0).
- IDX_W, max(1,$clog2(N_VEC)): derived index width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears FSM and all status outputs.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- vec_we  in  1  table write enable.
- vec_addr  in  IDX_W  table write index.
- vec_in  in  N_IN  input vector to store.
- vec_expected  in  N_OUT  expected output to store.
- dut_in  out  N_IN  registered stimulus to the gate under test.
- dut_out  in  N_OUT  gate response.
- busy  out  1  high from the cycle after start until done.
- done  out  1  level; high in DONE until the next start or reset.
- all_passed  out  1  valid while done; 1 if fail_count == 0.
- fail_count  out  IDX_W+1  number of mismatching vectors, saturating.
- first_fail_valid  out  1  set on the first mismatch of a run.
- first_fail_idx  out  IDX_W  index of the first mismatch.
- cur_idx  out  IDX_W  vector currently applied (debug).

Behaviour:
- Reset values: dut_in=0, busy=0, done=0, all_passed=0, fail_count=0, first_fail_valid=0, first_fail_idx=0, cur_idx=0; FSM enters IDLE. The vector table is not reset; its contents survive reset.
- Table writes take effect at the clock edge. vec_we is honoured only in IDLE and DONE and ignored while busy. vec_addr ≥ N_VEC is ignored.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE/DONE + start → APPLY. The same edge clears fail_count, first_fail_valid, first_fail_idx, cur_idx and done, and sets busy.
- APPLY: dut_in ← table_in[cur_idx]; settle counter ← SETTLE. Go to SETTLE, or straight to CHECK if SETTLE==0.
- SETTLE: decrement the counter each cycle; move to CHECK when it reaches 0. Total wait is SETTLE cycles.
- CHECK: compare dut_out to table_expected[cur_idx].
  - Comparison is case-equality: any X or Z bit in simulation counts as a mismatch.
  - On mismatch: fail_count increments, saturating at all-ones. If first_fail_valid==0, latch first_fail_idx←cur_idx and set first_fail_valid.
  - If cur_idx==N_VEC-1 → DONE. Otherwise cur_idx+1 → APPLY.
- DONE: busy=0, done=1, all_passed=(fail_count==0). dut_in holds the last vector.
- Cycle counts:
  - Per vector: SETTLE+2 cycles.
  - Run: start edge to done high is N_VEC·(SETTLE+2)+1 cycles.
- start while busy is ignored.
- start together with vec_we in IDLE: the write completes first; the run uses the new entry.
- Asynchronous reset mid-run aborts immediately, all outputs take their reset values, and no partial results are retained.
- N_VEC=1: a single APPLY/SETTLE/CHECK pass, then DONE.

Decomposition:
- Package gate_check_pkg:
  - FSM state enum (IDLE, APPLY, SETTLE, CHECK, DONE).
  - Function clog2_min1.
  - Localparam for the saturation limit.
- One natural sub-module: vector_table, a dual-port register array holding the input and expected fields. It has a synchronous write port and a combinational read port indexed by cur_idx.
- The FSM and counters stay in the top level.

Test Plan:
- Not gate, table {0→1, 1→0}, SETTLE=1, start → done high 7 cycles after the start edge; all_passed=1, fail_count=0, first_fail_valid=0; dut_in sequence 0 then 1.
- Same table with entry 1 expected corrupted to 1 → fail_count=1, first_fail_valid=1, first_fail_idx=1, all_passed=0.
- Both entries corrupted, SETTLE=0 → done 5 cycles after start; fail_count=2, first_fail_idx=0.
- Assert reset during SETTLE of vector 1, then start again → all outputs zero immediately after reset; the rerun passes with table contents intact.
- start pulsed and vec_we to addr 0 asserted mid-run → both ignored; results identical to the first scenario. A write in DONE followed by start uses the new value.
- Force dut_out to X during CHECK → counted as a mismatch; fail_count increments.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared types and helpers for the gate vector checker: FSM state encoding,
// index-width helper and the saturation pattern for the failure counter.
package gate_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Wide all-ones pattern; users slice it down to their counter width.
    localparam logic [63:0] SAT_ONES = {64{1'b1}};

    function automatic int clog2_min1(input int n);
        if (n <= 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/gate_vector_checker_vector_table.sv
// Vector table: synchronous write port, combinational read port. Not reset,
// so stored vectors survive a reset of the checker.
module vector_table
    import gate_check_pkg::*;
#(
    parameter int N_IN  = 1,
    parameter int N_OUT = 1,
    parameter int N_VEC = 2,
    parameter int IDX_W = clog2_min1(N_VEC)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [N_IN-1:0]  i_win,
    input  logic [N_OUT-1:0] i_wexp,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [N_IN-1:0]  o_rin,
    output logic [N_OUT-1:0] o_rexp
);

    logic [N_IN-1:0]  r_in_mem  [N_VEC];
    logic [N_OUT-1:0] r_exp_mem [N_VEC];

    // Write port; addresses beyond the table are dropped.
    always_ff @(posedge i_clk) begin
        if (i_we && (int'(i_waddr) < N_VEC)) begin
            r_in_mem[i_waddr]  <= i_win;
            r_exp_mem[i_waddr] <= i_wexp;
        end
    end

    assign o_rin  = r_in_mem[i_raddr];
    assign o_rexp = r_exp_mem[i_raddr];

endmodule

// File: rtl/gate_vector_checker.sv
// Stimulus/response engine: walks the vector table through a combinational
// gate, compares each settled response and reports pass/fail statistics.
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int N_IN   = 1,
    parameter int N_OUT  = 1,
    parameter int N_VEC  = 2,
    parameter int SETTLE = 1,
    parameter int IDX_W  = clog2_min1(N_VEC)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_vec_we,
    input  logic [IDX_W-1:0] i_vec_addr,
    input  logic [N_IN-1:0]  i_vec_in,
    input  logic [N_OUT-1:0] i_vec_expected,
    output logic [N_IN-1:0]  o_dut_in,
    input  logic [N_OUT-1:0] i_dut_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_all_passed,
    output logic [IDX_W:0]   o_fail_count,
    output logic             o_first_fail_valid,
    output logic [IDX_W-1:0] o_first_fail_idx,
    output logic [IDX_W-1:0] o_cur_idx
);

    localparam int               CNT_W       = clog2_min1(SETTLE + 1);
    localparam int               FC_W        = IDX_W + 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_VEC - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(32'd1);
    localparam logic [FC_W-1:0]  FAIL_SAT    = SAT_ONES[FC_W-1:0];
    localparam logic [FC_W-1:0]  FAIL_ONE    = FC_W'(32'd1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N_IN-1:0]  r_dut_in;
    logic             r_busy;
    logic             r_done;
    logic             r_all_passed;
    logic [FC_W-1:0]  r_fail_count;
    logic             r_first_fail_valid;
    logic [IDX_W-1:0] r_first_fail_idx;
    logic [IDX_W-1:0] r_cur_idx;

    logic             w_we;
    logic [N_IN-1:0]  w_tbl_in;
    logic [N_OUT-1:0] w_tbl_exp;
    logic             w_mismatch;
    logic             w_is_last;
    logic             w_fail_sat;

    // Table is only writable while no run is in flight.
    assign w_we = i_vec_we && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    vector_table #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .N_VEC (N_VEC),
        .IDX_W (IDX_W)
    ) u_vector_table (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (i_vec_addr),
        .i_win   (i_vec_in),
        .i_wexp  (i_vec_expected),
        .i_raddr (r_cur_idx),
        .o_rin   (w_tbl_in),
        .o_rexp  (w_tbl_exp)
    );

    // Case-inequality so an X or Z response is never mistaken for a match.
    assign w_mismatch = (i_dut_out !== w_tbl_exp);
    assign w_is_last  = (r_cur_idx == LAST_IDX);
    assign w_fail_sat = (r_fail_count == FAIL_SAT);

    // Run sequencer: state, settle counter, stimulus register and status.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state            <= ST_IDLE;
            r_cnt              <= '0;
            r_dut_in           <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_all_passed       <= 1'b0;
            r_fail_count       <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_idx   <= '0;
            r_cur_idx          <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state            <= ST_APPLY;
                        r_busy             <= 1'b1;
                        r_done             <= 1'b0;
                        r_all_passed       <= 1'b0;
                        r_fail_count       <= '0;
                        r_first_fail_valid <= 1'b0;
                        r_first_fail_idx   <= '0;
                        r_cur_idx          <= '0;
                    end else if (r_state == ST_DONE) begin
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_all_passed <= (r_fail_count == '0);
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    r_dut_in <= w_tbl_in;
                    r_cnt    <= SETTLE_LOAD;
                    if (SETTLE == 0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Counter holds the remaining wait cycles including this one.
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt <= CNT_ONE) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_CHECK: begin
                    if (w_mismatch) begin
                        if (!w_fail_sat) begin
                            r_fail_count <= r_fail_count + FAIL_ONE;
                        end
                        if (!r_first_fail_valid) begin
                            r_first_fail_valid <= 1'b1;
                            r_first_fail_idx   <= r_cur_idx;
                        end
                    end
                    if (w_is_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cur_idx <= r_cur_idx + IDX_ONE;
                        r_state   <= ST_APPLY;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_dut_in           = r_dut_in;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_all_passed       = r_all_passed;
    assign o_fail_count       = r_fail_count;
    assign o_first_fail_valid = r_first_fail_valid;
    assign o_first_fail_idx   = r_first_fail_idx;
    assign o_cur_idx          = r_cur_idx;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench: two checkers (SETTLE=1 and SETTLE=0) share table/start stimulus and
// each wraps a 1-bit Not gate; results are compared against a table-level model.
module tb_gate_vector_checker;

    localparam int N_VEC = 2;
    localparam int LAT_A = N_VEC * (1 + 2) + 1;
    localparam int LAT_B = N_VEC * (0 + 2) + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       vec_we;
    logic [0:0] vec_addr;
    logic [0:0] vec_in;
    logic [0:0] vec_exp;
    logic       force_x;

    logic [0:0] a_dut_in, a_dut_out, b_dut_in, b_dut_out;
    logic       a_busy, a_done, a_ap, a_ffv;
    logic       b_busy, b_done, b_ap, b_ffv;
    logic [1:0] a_fc, b_fc;
    logic [0:0] a_ffi, a_ci, b_ffi, b_ci;

    int n_cmp = 0;
    int n_bad = 0;

    logic [0:0] m_in  [N_VEC];
    logic [0:0] m_exp [N_VEC];

    always #5 clk = ~clk;

    assign a_dut_out = force_x ? 1'bx : ~a_dut_in;
    assign b_dut_out = ~b_dut_in;

    gate_vector_checker #(.N_IN(1), .N_OUT(1), .N_VEC(N_VEC), .SETTLE(1)) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_vec_we(vec_we),
        .i_vec_addr(vec_addr), .i_vec_in(vec_in), .i_vec_expected(vec_exp),
        .o_dut_in(a_dut_in), .i_dut_out(a_dut_out), .o_busy(a_busy), .o_done(a_done),
        .o_all_passed(a_ap), .o_fail_count(a_fc), .o_first_fail_valid(a_ffv),
        .o_first_fail_idx(a_ffi), .o_cur_idx(a_ci)
    );

    gate_vector_checker #(.N_IN(1), .N_OUT(1), .N_VEC(N_VEC), .SETTLE(0)) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_vec_we(vec_we),
        .i_vec_addr(vec_addr), .i_vec_in(vec_in), .i_vec_expected(vec_exp),
        .o_dut_in(b_dut_in), .i_dut_out(b_dut_out), .o_busy(b_busy), .o_done(b_done),
        .o_all_passed(b_ap), .o_fail_count(b_fc), .o_first_fail_valid(b_ffv),
        .o_first_fail_idx(b_ffi), .o_cur_idx(b_ci)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a vector fails when the Not of its input differs from its
    // expected value, or always when the response is forced unknown.
    function automatic int model_fails(input bit xmode, output int first);
        int n;
        n     = 0;
        first = -1;
        for (int i = 0; i < N_VEC; i++) begin
            if (xmode || ((~m_in[i]) != m_exp[i])) begin
                if (first < 0) first = i;
                n++;
            end
        end
        return (n > 3) ? 3 : n;
    endfunction

    task automatic tbl_write(input int addr, input logic din, input logic dexp);
        vec_we   = 1'b1;
        vec_addr = 1'(addr);
        vec_in   = din;
        vec_exp  = dexp;
        @(negedge clk);
        vec_we = 1'b0;
        m_in[addr]  = din;
        m_exp[addr] = dexp;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_check(input string tag, input bit xmode, input bit disturb,
                             input int abort_at, input bit wr, input logic din,
                             input logic dexp);
        int a_lat, b_lat, a_fe, b_fe, a_nf, b_nf;
        a_lat = -1;
        b_lat = -1;
        vec_we   = wr;
        vec_addr = 1'b0;
        vec_in   = din;
        vec_exp  = dexp;
        if (wr) begin
            m_in[0]  = din;
            m_exp[0] = dexp;
        end
        start   = 1'b1;
        force_x = xmode;
        @(negedge clk);
        start  = 1'b0;
        vec_we = 1'b0;
        chk({tag, "/start_flags"}, 32'({a_busy, a_done, b_busy, b_done}), 32'b1010);
        chk({tag, "/start_clear"}, 32'({a_fc, a_ffv, b_fc, b_ffv}), 32'd0);
        a_nf = model_fails(xmode, a_fe);
        b_nf = model_fails(1'b0, b_fe);
        for (int cyc = 1; cyc <= 40 && (a_lat < 0 || b_lat < 0); cyc++) begin
            if (disturb && cyc == 2) begin
                start    = 1'b1;
                vec_we   = 1'b1;
                vec_addr = 1'b0;
                vec_in   = ~m_in[0];
                vec_exp  = ~m_exp[0];
            end
            @(negedge clk);
            start  = 1'b0;
            vec_we = 1'b0;
            if ((cyc - 1) % 3 == 0 && (cyc - 1) / 3 < N_VEC) begin
                chk({tag, "/a_dut_in"}, 32'(a_dut_in), 32'(m_in[(cyc - 1) / 3]));
                chk({tag, "/a_cur_idx"}, 32'(a_ci), 32'((cyc - 1) / 3));
            end
            if ((cyc - 1) % 2 == 0 && (cyc - 1) / 2 < N_VEC) begin
                chk({tag, "/b_dut_in"}, 32'(b_dut_in), 32'(m_in[(cyc - 1) / 2]));
            end
            if (cyc == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk({tag, "/a_reset_outs"},
                    32'({a_dut_in, a_busy, a_done, a_ap, a_fc, a_ffv, a_ffi, a_ci}), 32'd0);
                chk({tag, "/b_reset_outs"},
                    32'({b_dut_in, b_busy, b_done, b_ap, b_fc, b_ffv, b_ffi, b_ci}), 32'd0);
                rst     = 1'b0;
                force_x = 1'b0;
                @(negedge clk);
                return;
            end
            if (a_lat < 0 && a_done) a_lat = cyc;
            if (b_lat < 0 && b_done) b_lat = cyc;
        end
        force_x = 1'b0;
        chk({tag, "/a_latency"}, 32'(a_lat), 32'(LAT_A));
        chk({tag, "/b_latency"}, 32'(b_lat), 32'(LAT_B));
        chk({tag, "/a_result"}, 32'({a_busy, a_ap, a_fc, a_ffv, a_ffi}),
            32'({1'b0, a_nf == 0, 2'(a_nf), a_nf > 0, 1'(a_fe < 0 ? 0 : a_fe)}));
        chk({tag, "/b_result"}, 32'({b_busy, b_ap, b_fc, b_ffv, b_ffi}),
            32'({1'b0, b_nf == 0, 2'(b_nf), b_nf > 0, 1'(b_fe < 0 ? 0 : b_fe)}));
        chk({tag, "/a_hold_last"}, 32'(a_dut_in), 32'(m_in[N_VEC - 1]));
    endtask

    initial begin
        logic din, dexp;
        int   nw;
        rst      = 1'b1;
        start    = 1'b0;
        vec_we   = 1'b0;
        vec_addr = 1'b0;
        vec_in   = 1'b0;
        vec_exp  = 1'b0;
        force_x  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_a", 32'({a_dut_in, a_busy, a_done, a_ap, a_fc, a_ffv, a_ffi, a_ci}), 32'd0);
        chk("reset_b", 32'({b_dut_in, b_busy, b_done, b_ap, b_fc, b_ffv, b_ffi, b_ci}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        tbl_write(0, 1'b0, 1'b1);
        tbl_write(1, 1'b1, 1'b0);
        run_check("not_pass", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

        tbl_write(1, 1'b1, 1'b1);
        run_check("corrupt_e1", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

        tbl_write(0, 1'b0, 1'b0);
        run_check("corrupt_both", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

        tbl_write(0, 1'b0, 1'b1);
        tbl_write(1, 1'b1, 1'b0);
        run_check("abort", 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
        run_check("rerun", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        run_check("disturb", 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b0);

        tbl_write(1, 1'b1, 1'b1);
        run_check("write_in_done", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        run_check("write_with_start", 1'b0, 1'b0, -1, 1'b1, 1'b0, 1'b0);

        tbl_write(0, 1'b0, 1'b1);
        tbl_write(1, 1'b1, 1'b1);
        run_check("x_response", 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);

        repeat (12) begin
            nw = $urandom_range(0, 3);
            for (int j = 0; j < nw; j++) begin
                din  = 1'($urandom_range(0, 1));
                dexp = 1'($urandom_range(0, 1));
                tbl_write($urandom_range(0, N_VEC - 1), din, dexp);
            end
            din  = 1'($urandom_range(0, 1));
            dexp = 1'($urandom_range(0, 1));
            run_check("rand", 1'b0, 1'($urandom_range(0, 1)), -1,
                      1'($urandom_range(0, 1)), din, dexp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
